// File: rtl/mem_arbiter_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr_pkg
// Purpose  : Shared types and constants for the memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_rr_pkg;

    localparam int ADDRESS_WIDTH       = 32;
    localparam int CACHE_LINE_WIDTH    = 128;
    localparam int ARB_NUM_REQ_DEFAULT = 2;

    localparam int ARB_DCACHE = 0;
    localparam int ARB_ICACHE = 1;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr_picker
// Purpose  : Finds the first active request at or after a start index,
//            wrapping modulo NUM_REQ (rotate + priority encode).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    localparam logic [IDX_W:0] c_num_req = (IDX_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_offset;
    logic [IDX_W:0]     w_sum;

    // Doubling the vector lets a plain right shift act as a rotate.
    assign w_rot = NUM_REQ'({req, req} >> start);

    always_comb begin
        found    = 1'b0;
        w_offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found    = 1'b1;
                w_offset = IDX_W'(i);
            end
        end
    end

    assign w_sum  = {1'b0, start} + {1'b0, w_offset};
    assign winner = (w_sum >= c_num_req) ? IDX_W'(w_sum - c_num_req) : w_sum[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr
// Purpose  : Locking N-requester arbiter for the shared memory port.
//            ARB_ROUND_ROBIN_EN selects round robin; otherwise lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ_DEFAULT,
    parameter  int ADDR_W  = ADDRESS_WIDTH,
    parameter  int DATA_W  = CACHE_LINE_WIDTH,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               write_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   data_i,
    input  logic                             mem_ready_i,
    output logic [NUM_REQ-1:0]               grant_o,
    output logic [NUM_REQ-1:0]               ready_o,
    output logic                             mem_req_o,
    output logic                             mem_write_o,
    output logic [ADDR_W-1:0]                mem_addr_o,
    output logic [DATA_W-1:0]                mem_data_o,
    output logic [IDX_W-1:0]                 owner_o
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_winner;
    logic             w_found;
    logic             w_grant_issue;
    logic             w_active;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= c_last_idx;
        end else if (w_grant_issue) begin
            r_rr_ptr <= w_winner;
        end
    end

    assign w_start = (r_rr_ptr == c_last_idx) ? '0 : r_rr_ptr + IDX_W'(1);
`else
    assign w_start = '0;
`endif

    mem_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb_picker (
        .req    (req_i),
        .start  (w_start),
        .found  (w_found),
        .winner (w_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_issue) begin
                r_owner <= w_winner;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_issue = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = ARB_BUSY;
                    w_grant_issue = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (!req_i[r_owner]) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // The owner's own request gates the outputs so release takes effect in the same cycle.
    assign w_active = !reset && (r_state == ARB_BUSY) && req_i[r_owner];

    always_comb begin
        grant_o     = '0;
        ready_o     = '0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        owner_o     = '0;
        if (w_active) begin
            grant_o[r_owner] = 1'b1;
            ready_o[r_owner] = mem_ready_i;
            mem_req_o        = 1'b1;
            mem_write_o      = write_i[r_owner];
            mem_addr_o       = addr_i[r_owner];
            mem_data_o       = data_i[r_owner];
            owner_o          = r_owner;
        end
    end

endmodule
`default_nettype wire
